tone_scheduler: RTL and testbench
=================================

TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 Parameter NOTE_CYCLES, default 25_000_000, clock cycles one note sounds; SHALL be >= 1.
REQ-002 Parameter GAP_CYCLES, default 2_500_000, silent cycles after every note; SHALL be >= 1.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_err  input  1  error-sound request, level.
REQ-006 req_win  input  1  victory-jingle request, level.
REQ-007 req_seq  input  1  sequence-display note request, level; note on seq_note.
REQ-008 seq_note  input  4  note code for req_seq, valid while req_seq=1.
REQ-009 req_btn  input  1  button-feedback note request, level; note on btn_note.
REQ-010 btn_note  input  4  note code for req_btn, valid while req_btn=1.
REQ-011 stop  input  1  synchronous abort of any playback.
REQ-012 ack  output  4  one-cycle one-hot acceptance pulse {err,win,seq,btn}.
REQ-013 done  output  4  one-cycle one-hot completion pulse {err,win,seq,btn}.
REQ-014 tone_en  output  1  tone generator enable.
REQ-015 tone_sel  output  4  note code driven to tone generator.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 db_estado  output  3  current state encoding for debug display.

Function
REQ-018 States SHALL be IDLE=0, PLAY=1, GAP=2.
REQ-019 Requests SHALL be sampled only in IDLE; fixed priority err > win > seq > btn; ties resolved by priority, losers ignored.
REQ-020 On acceptance edge: ack bit of winner pulses that cycle, note list latched, state -> PLAY; tone_en=1 from the next cycle.
REQ-021 Note lists: err = {F,F}; win = {A,B,C,D}; seq = {latched seq_note}; btn = {latched btn_note}.
REQ-022 PLAY SHALL hold tone_en=1, tone_sel=current note for exactly NOTE_CYCLES cycles, then -> GAP.
REQ-023 GAP SHALL hold tone_en=0 for exactly GAP_CYCLES cycles; then, if notes remain, -> PLAY with next note; else done bit of owner pulses one cycle and -> IDLE.
REQ-024 Preemption: req_err=1 while owner is seq or btn (PLAY or GAP) SHALL abort current owner without done, pulse ack[err], restart in PLAY with err list; win and err owners are never preempted.
REQ-025 stop=1 SHALL force IDLE next edge, tone_en=0, no done pulse; stop overrides simultaneous requests and preemption.
REQ-026 A request still high when its done pulses SHALL NOT be re-accepted in that cycle; earliest re-acceptance is the following IDLE cycle.
REQ-027 tone_sel SHALL be 0 whenever tone_en=0.
REQ-028 Duration counter width SHALL be clog2 of max(NOTE_CYCLES,GAP_CYCLES)+1; counter reloads on every state entry, no wrap.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, counter=0, note index=0, ack=0, done=0, tone_en=0, tone_sel=0, busy=0, db_estado=0.
REQ-030 reset mid-playback SHALL discard owner and note list; no done pulse after release.

Structure
REQ-031 Shared package SHALL hold state encodings, note codes (A..D, F), err/win note tables and list lengths.
REQ-032 One sub-module tone_timer (load, count, expire) SHALL implement the duration counter; FSM and arbitration stay in tone_scheduler.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2)
REQ-033 req_btn=1, btn_note=3 in IDLE -> ack=0001 one cycle; tone_en=1, tone_sel=3 for 4 cycles; 2 silent; done=0001; busy falls.
REQ-034 req_seq and req_btn same cycle -> ack=0010 only; btn ignored until IDLE returns.
REQ-035 req_win -> tone_sel A,B,C,D, each 4 on / 2 off; single done=0100 after 24 cycles from first tone.
REQ-036 req_err during seq note cycle 2 -> seq done never pulses; ack=1000; F,F played; done=1000.
REQ-037 stop during win note B -> IDLE next edge, tone_en=0, no done; reset mid-GAP -> all outputs 0 immediately.

Source files
------------

// File: rtl/tone_scheduler_pkg.sv
// Shared encodings for the tone scheduler: states, playback owners, note codes
// and the fixed note tables for the error sound and the victory jingle.
package tone_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_GAP  = 3'd2
    } state_t;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_ERR,
        OWN_WIN,
        OWN_SEQ,
        OWN_BTN
    } owner_t;

    localparam logic [3:0] NOTE_A = 4'd1;
    localparam logic [3:0] NOTE_B = 4'd2;
    localparam logic [3:0] NOTE_C = 4'd3;
    localparam logic [3:0] NOTE_D = 4'd4;
    localparam logic [3:0] NOTE_F = 4'd6;

    localparam int ERR_LEN = 2;
    localparam int WIN_LEN = 4;
    localparam int IDX_W   = 2;

    // Element [0] is played first.
    localparam logic [ERR_LEN-1:0][3:0] ERR_NOTES = {NOTE_F, NOTE_F};
    localparam logic [WIN_LEN-1:0][3:0] WIN_NOTES = {NOTE_D, NOTE_C, NOTE_B, NOTE_A};

    // One-hot position in the {err,win,seq,btn} ack/done vectors.
    function automatic logic [3:0] ownerBit(input owner_t o);
        case (o)
            OWN_ERR: ownerBit = 4'b1000;
            OWN_WIN: ownerBit = 4'b0100;
            OWN_SEQ: ownerBit = 4'b0010;
            OWN_BTN: ownerBit = 4'b0001;
            default: ownerBit = 4'b0000;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] lastIdx(input owner_t o);
        case (o)
            OWN_ERR: lastIdx = IDX_W'(ERR_LEN - 1);
            OWN_WIN: lastIdx = IDX_W'(WIN_LEN - 1);
            default: lastIdx = '0;
        endcase
    endfunction

endpackage

// File: rtl/tone_scheduler_timer.sv
// Duration counter: loads a cycle count, counts down to zero and holds there.
module tone_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         count,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= loadVal;
        else if (count && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates sound requests and sequences their notes through PLAY/GAP phases,
// driving a tone generator enable and note code.
module tone_scheduler
    import tone_scheduler_pkg::*;
#(
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_err,
    input  logic       req_win,
    input  logic       req_seq,
    input  logic [3:0] seq_note,
    input  logic       req_btn,
    input  logic [3:0] btn_note,
    input  logic       stop,
    output logic [3:0] ack,
    output logic [3:0] done,
    output logic       tone_en,
    output logic [3:0] tone_sel,
    output logic       busy,
    output logic [2:0] db_estado
);

    localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] NOTE_LD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, stateNext;
    owner_t           owner, ownerNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [3:0]       noteReg, noteNext;
    logic [3:0]       ackNext, doneNext;
    logic [3:0]       reqVec;
    logic [3:0]       curNote;
    logic             start, preempt;
    logic             tLoad, expire;
    logic [CNT_W-1:0] tLoadVal;

    tone_timer #(.W(CNT_W)) uTimer (
        .clock   (clock),
        .reset   (reset),
        .load    (tLoad),
        .loadVal (tLoadVal),
        .count   (state != ST_IDLE),
        .expire  (expire)
    );

    // A request whose done is pulsing this cycle is masked so it cannot retrigger at once.
    assign reqVec  = {req_err, req_win, req_seq, req_btn} & ~done;
    assign preempt = req_err && (owner == OWN_SEQ || owner == OWN_BTN);

    always_comb begin
        case (owner)
            OWN_ERR: curNote = ERR_NOTES[idx[0]];
            OWN_WIN: curNote = WIN_NOTES[idx];
            default: curNote = noteReg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            idx     <= '0;
            noteReg <= '0;
            ack     <= '0;
            done    <= '0;
        end else begin
            state   <= stateNext;
            owner   <= ownerNext;
            idx     <= idxNext;
            noteReg <= noteNext;
            ack     <= ackNext;
            done    <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        ownerNext = owner;
        idxNext   = idx;
        noteNext  = noteReg;
        ackNext   = '0;
        doneNext  = '0;
        tLoad     = 1'b0;
        tLoadVal  = '0;
        start     = 1'b0;
        if (stop) begin
            stateNext = ST_IDLE;
            ownerNext = OWN_NONE;
            idxNext   = '0;
            tLoad     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    start = 1'b1;
                    if (reqVec[3])
                        ownerNext = OWN_ERR;
                    else if (reqVec[2])
                        ownerNext = OWN_WIN;
                    else if (reqVec[1]) begin
                        ownerNext = OWN_SEQ;
                        noteNext  = seq_note;
                    end else if (reqVec[0]) begin
                        ownerNext = OWN_BTN;
                        noteNext  = btn_note;
                    end else
                        start = 1'b0;
                end
                ST_PLAY: begin
                    if (preempt) begin
                        ownerNext = OWN_ERR;
                        start     = 1'b1;
                    end else if (expire) begin
                        stateNext = ST_GAP;
                        tLoad     = 1'b1;
                        tLoadVal  = GAP_LD;
                    end
                end
                ST_GAP: begin
                    if (preempt) begin
                        ownerNext = OWN_ERR;
                        start     = 1'b1;
                    end else if (expire) begin
                        if (idx == lastIdx(owner)) begin
                            stateNext = ST_IDLE;
                            doneNext  = ownerBit(owner);
                            ownerNext = OWN_NONE;
                            idxNext   = '0;
                            tLoad     = 1'b1;
                        end else begin
                            stateNext = ST_PLAY;
                            idxNext   = idx + 1'b1;
                            tLoad     = 1'b1;
                            tLoadVal  = NOTE_LD;
                        end
                    end
                end
                default: begin
                    stateNext = ST_IDLE;
                    ownerNext = OWN_NONE;
                    idxNext   = '0;
                    tLoad     = 1'b1;
                end
            endcase
            if (start) begin
                stateNext = ST_PLAY;
                idxNext   = '0;
                tLoad     = 1'b1;
                tLoadVal  = NOTE_LD;
                ackNext   = ownerBit(ownerNext);
            end
        end
    end

    assign tone_en   = (state == ST_PLAY);
    assign tone_sel  = tone_en ? curNote : 4'd0;
    assign busy      = (state != ST_IDLE);
    assign db_estado = state;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with NOTE_CYCLES=4, GAP_CYCLES=2.
module tb_tone_scheduler;

    logic       clock, reset;
    logic       req_err, req_win, req_seq, req_btn, stop;
    logic [3:0] seq_note, btn_note;
    logic [3:0] ack, done, tone_sel;
    logic       tone_en, busy;
    logic [2:0] db_estado;

    int nChecks = 0;
    int nFails  = 0;

    tone_scheduler #(.NOTE_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_err   (req_err),
        .req_win   (req_win),
        .req_seq   (req_seq),
        .seq_note  (seq_note),
        .req_btn   (req_btn),
        .btn_note  (btn_note),
        .stop      (stop),
        .ack       (ack),
        .done      (done),
        .tone_en   (tone_en),
        .tone_sel  (tone_sel),
        .busy      (busy),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected note codes, written out independently of the design package.
    localparam logic [3:0] A = 4'd1, B = 4'd2, C = 4'd3, D = 4'd4, F = 4'd6;

    typedef struct {
        logic        e, w, s, b, st;
        logic [3:0]  sn, bn;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {ack, done, tone_en, tone_sel, busy, db_estado}
    function automatic logic [16:0] mk(input logic [3:0] a, input logic [3:0] d, input logic en,
                                       input logic [3:0] sel, input logic bz, input logic [2:0] st);
        return {a, d, en, sel, bz, st};
    endfunction

    function automatic logic [16:0] obs();
        return {ack, done, tone_en, tone_sel, busy, db_estado};
    endfunction

    task automatic addVec(input logic e, input logic w, input logic s, input logic [3:0] sn,
                          input logic b, input logic [3:0] bn, input logic st, input logic [16:0] exp);
        vec_t v;
        v.e = e; v.w = w; v.s = s; v.sn = sn; v.b = b; v.bn = bn; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearIn();
        req_err = 0; req_win = 0; req_seq = 0; req_btn = 0; stop = 0;
        seq_note = 0; btn_note = 0;
    endtask

    initial begin
        clearIn();
        reset = 1'b1;
        #3;
        chk("reset_state", 32'(obs()), 32'd0);
        step(); step();
        reset = 1'b0;

        // Button note held high across its own done, then stop; stop beats requests.
        addVec(0,0,0,0, 1,3, 0, mk(4'b0001,0,1,3,1,1));
        for (int i = 0; i < 3; i++) addVec(0,0,0,0, 1,3, 0, mk(0,0,1,3,1,1));
        for (int i = 0; i < 2; i++) addVec(0,0,0,0, 1,3, 0, mk(0,0,0,0,1,2));
        addVec(0,0,0,0, 1,3, 0, mk(0,4'b0001,0,0,0,0));
        addVec(0,0,0,0, 1,3, 0, mk(0,0,0,0,0,0));
        addVec(0,0,0,0, 1,3, 0, mk(4'b0001,0,1,3,1,1));
        addVec(0,0,0,0, 0,0, 1, mk(0,0,0,0,0,0));
        addVec(1,0,0,0, 1,3, 1, mk(0,0,0,0,0,0));
        // seq vs btn tie: seq wins with its latched note; btn taken once IDLE returns.
        addVec(0,0,1,7, 1,3, 0, mk(4'b0010,0,1,7,1,1));
        for (int i = 0; i < 3; i++) addVec(0,0,0,0, 1,3, 0, mk(0,0,1,7,1,1));
        for (int i = 0; i < 2; i++) addVec(0,0,0,0, 1,3, 0, mk(0,0,0,0,1,2));
        addVec(0,0,0,0, 1,3, 0, mk(0,4'b0010,0,0,0,0));
        addVec(0,0,0,0, 1,3, 0, mk(4'b0001,0,1,3,1,1));
        addVec(0,0,0,0, 0,0, 1, mk(0,0,0,0,0,0));

        foreach (vecs[i]) begin
            req_err = vecs[i].e; req_win = vecs[i].w; req_seq = vecs[i].s; seq_note = vecs[i].sn;
            req_btn = vecs[i].b; btn_note = vecs[i].bn; stop = vecs[i].st;
            step();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end
        clearIn();
        step();

        // Victory jingle: A,B,C,D each 4 on / 2 off, one done 24 cycles after first tone.
        begin
            logic [3:0] winNotes [4];
            winNotes[0] = A; winNotes[1] = B; winNotes[2] = C; winNotes[3] = D;
            req_win = 1;
            step();
            req_win = 0;
            chk("win_ack", 32'(ack), 32'(4'b0100));
            for (int n = 0; n < 4; n++) begin
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("win_n%0d_on%0d", n, c), 32'({tone_en, tone_sel, done}), 32'({1'b1, winNotes[n], 4'd0}));
                    step();
                end
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("win_n%0d_gap%0d", n, c), 32'({tone_en, tone_sel, done, busy}), 32'({1'b0, 4'd0, 4'd0, 1'b1}));
                    step();
                end
            end
            chk("win_done", 32'({done, busy}), 32'({4'b0100, 1'b0}));
            step();
        end

        // Error preempts a seq note in its second cycle; seq never completes.
        req_seq = 1; seq_note = 4'd8;
        step();
        req_seq = 0;
        chk("pre_seq_ack", 32'({ack, tone_sel}), 32'({4'b0010, 4'd8}));
        step();
        req_err = 1;
        step();
        req_err = 0;
        chk("pre_err_ack", 32'(ack), 32'(4'b1000));
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("err_c%0d", n), 32'({tone_en, tone_sel, done}),
                32'({((n % 6) < 4), ((n % 6) < 4) ? F : 4'd0, 4'd0}));
            step();
        end
        chk("err_done", 32'({done, busy}), 32'({4'b1000, 1'b0}));
        step();

        // Stop during the second jingle note: idle next edge, no done ever.
        req_win = 1;
        step();
        req_win = 0;
        for (int c = 0; c < 7; c++) step();
        chk("stop_pre_B", 32'({tone_en, tone_sel}), 32'({1'b1, B}));
        stop = 1;
        step();
        stop = 0;
        chk("stop_idle", 32'(obs()), 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("stop_quiet%0d", c), 32'({done, busy}), 32'd0);
            step();
        end

        // Async reset in the middle of a GAP clears everything immediately.
        req_btn = 1; btn_note = 4'd5;
        step();
        req_btn = 0;
        for (int c = 0; c < 4; c++) step();
        chk("rst_in_gap", 32'(db_estado), 32'd2);
        reset = 1;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        step(); step();
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("rst_quiet%0d", c), 32'(obs()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
